// File: rtl/alarm_time_counter.sv
// 24-hour BCD time-of-day counter for the alarm clock: advances one minute every SEC_PER_MIN ticks.
// Optional macro LOAD_CHECK_EN rejects out-of-range loads and adds the load_err pulse output.
module alarm_time_counter #(
    parameter int SEC_PER_MIN = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
`ifdef LOAD_CHECK_EN
    output logic       load_err,
`endif
    output logic       minute_tick
);

    localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

    logic [5:0] sec_cnt_q, sec_cnt_d;
    logic [3:0] ms_hr_q, ms_hr_d;
    logic [3:0] ls_hr_q, ls_hr_d;
    logic [3:0] ms_min_q, ms_min_d;
    logic [3:0] ls_min_q, ls_min_d;
    logic       minute_tick_q, minute_tick_d;
    logic       load_accept;

`ifdef LOAD_CHECK_EN
    logic load_err_q, load_err_d;

    assign load_accept = (new_current_time_ms_hr <= 4'd2) && (new_current_time_ls_hr <= 4'd9) &&
                         (new_current_time_ms_min <= 4'd5) && (new_current_time_ls_min <= 4'd9) &&
                         ((new_current_time_ms_hr < 4'd2) || (new_current_time_ls_hr <= 4'd3));
    assign load_err_d  = load_new_c && !load_accept;
`else
    assign load_accept = 1'b1;
`endif

    // Load beats the second tick; a rejected load still swallows a coincident tick.
    always_comb begin
        sec_cnt_d     = sec_cnt_q;
        ms_hr_d       = ms_hr_q;
        ls_hr_d       = ls_hr_q;
        ms_min_d      = ms_min_q;
        ls_min_d      = ls_min_q;
        minute_tick_d = 1'b0;
        if (load_new_c) begin
            if (load_accept) begin
                sec_cnt_d = 6'd0;
                ms_hr_d   = new_current_time_ms_hr;
                ls_hr_d   = new_current_time_ls_hr;
                ms_min_d  = new_current_time_ms_min;
                ls_min_d  = new_current_time_ls_min;
            end
        end else if (one_second) begin
            if (sec_cnt_q < SEC_LAST) begin
                sec_cnt_d = sec_cnt_q + 6'd1;
            end else begin
                sec_cnt_d     = 6'd0;
                minute_tick_d = 1'b1;
                // >= comparisons let out-of-range digits fold back into BCD on carry.
                if (ls_min_q >= 4'd9) begin
                    ls_min_d = 4'd0;
                    if (ms_min_q >= 4'd5) begin
                        ms_min_d = 4'd0;
                        if ((ms_hr_q == 4'd2 && ls_hr_q >= 4'd3) || ms_hr_q > 4'd2) begin
                            ms_hr_d = 4'd0;
                            ls_hr_d = 4'd0;
                        end else if (ls_hr_q >= 4'd9) begin
                            ls_hr_d = 4'd0;
                            ms_hr_d = ms_hr_q + 4'd1;
                        end else begin
                            ls_hr_d = ls_hr_q + 4'd1;
                        end
                    end else begin
                        ms_min_d = ms_min_q + 4'd1;
                    end
                end else begin
                    ls_min_d = ls_min_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sec_cnt_q     <= 6'd0;
            ms_hr_q       <= 4'd0;
            ls_hr_q       <= 4'd0;
            ms_min_q      <= 4'd0;
            ls_min_q      <= 4'd0;
            minute_tick_q <= 1'b0;
        end else begin
            sec_cnt_q     <= sec_cnt_d;
            ms_hr_q       <= ms_hr_d;
            ls_hr_q       <= ls_hr_d;
            ms_min_q      <= ms_min_d;
            ls_min_q      <= ls_min_d;
            minute_tick_q <= minute_tick_d;
        end
    end

`ifdef LOAD_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`endif

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min_q;
    assign current_time_ls_min = ls_min_q;
    assign minute_tick         = minute_tick_q;

endmodule

// File: tb/tb_alarm_time_counter.sv
// Directed bench for alarm_time_counter with SEC_PER_MIN=4; covers both LOAD_CHECK_EN builds.
module tb_alarm_time_counter;

    localparam int SPM = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] new_ms_hr = 4'd0, new_ls_hr = 4'd0, new_ms_min = 4'd0, new_ls_min = 4'd0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       minute_tick;
`ifdef LOAD_CHECK_EN
    logic       load_err;
`endif
    logic [15:0] cur;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int tick_base;

    alarm_time_counter #(.SEC_PER_MIN(SPM)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .one_second              (one_second),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (new_ms_hr),
        .new_current_time_ls_hr  (new_ls_hr),
        .new_current_time_ms_min (new_ms_min),
        .new_current_time_ls_min (new_ls_min),
        .current_time_ms_hr      (ms_hr),
        .current_time_ls_hr      (ls_hr),
        .current_time_ms_min     (ms_min),
        .current_time_ls_min     (ls_min),
`ifdef LOAD_CHECK_EN
        .load_err                (load_err),
`endif
        .minute_tick             (minute_tick)
    );

    // Clock and reset
    always #5 clock = ~clock;

    assign cur = {ms_hr, ls_hr, ms_min, ls_min};

    // Count minute_tick cycles, sampled shortly after each rising edge.
    always @(posedge clock) begin
        #2;
        if (minute_tick === 1'b1) tick_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change on falling edges and return on a falling edge.
    task automatic drive_load(input logic [15:0] t, input logic with_sec);
        @(negedge clock);
        {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = t;
        load_new_c = 1'b1;
        one_second = with_sec;
        @(negedge clock);
        load_new_c = 1'b0;
        one_second = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            one_second = 1'b1;
            @(negedge clock);
            one_second = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wrap_case(input string tag, input logic [15:0] start, input logic [15:0] exp);
        drive_load(start, 1'b0);
        tick_base = tick_cnt;
        pulses(SPM - 1);
        check({tag, "_pre"}, cur, start);
        pulses(1);
        idle(1);
        check(tag, cur, exp);
        check({tag, "_ticks"}, 16'(tick_cnt - tick_base), 16'd1);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_time", cur, 16'h0000);
        check("rst_tick", {15'd0, minute_tick}, 16'd0);
`ifdef LOAD_CHECK_EN
        check("rst_err", {15'd0, load_err}, 16'd0);
`endif
        reset = 1'b1;

        drive_load(16'h1234, 1'b0);
        check("load_1234", cur, 16'h1234);
        idle(2);
        check("hold_1234", cur, 16'h1234);
        pulses(SPM);
        check("adv_1235", cur, 16'h1235);
        check("tick_high", {15'd0, minute_tick}, 16'd1);
        @(negedge clock);
        check("tick_low", {15'd0, minute_tick}, 16'd0);

        // Async reset while minute_tick is high
        drive_load(16'h1258, 1'b0);
        pulses(SPM);
        check("adv_1259", cur, 16'h1259);
        #1 reset = 1'b0;
        #1;
        check("rst_async_time", cur, 16'h0000);
        check("rst_async_tick", {15'd0, minute_tick}, 16'd0);
        idle(2);
        reset = 1'b1;

        // Async reset mid-minute must clear the seconds count
        drive_load(16'h1234, 1'b0);
        pulses(2);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_time", cur, 16'h0000);
        idle(1);
        reset = 1'b1;
        tick_base = tick_cnt;
        pulses(SPM - 1);
        check("post_rst_pre", cur, 16'h0000);
        check("post_rst_noticks", 16'(tick_cnt - tick_base), 16'd0);
        pulses(1);
        idle(1);
        check("post_rst_0001", cur, 16'h0001);
        check("post_rst_ticks", 16'(tick_cnt - tick_base), 16'd1);

        // Carry-chain wraps
        wrap_case("wrap_2359", 16'h2359, 16'h0000);
        wrap_case("wrap_0959", 16'h0959, 16'h1000);
        wrap_case("wrap_1959", 16'h1959, 16'h2000);
        wrap_case("wrap_1049", 16'h1049, 16'h1050);

        // Load coincident with the rollover tick
        pulses(SPM - 1);
        tick_base = tick_cnt;
        drive_load(16'h0715, 1'b1);
        idle(1);
        check("simul_load", cur, 16'h0715);
        check("simul_noticks", 16'(tick_cnt - tick_base), 16'd0);
        pulses(SPM - 1);
        check("simul_pre", cur, 16'h0715);
        pulses(1);
        check("simul_0716", cur, 16'h0716);

        // Load restarts the minute
        pulses(SPM - 1);
        drive_load(16'h1111, 1'b0);
        pulses(SPM - 1);
        check("restart_pre", cur, 16'h1111);
        pulses(1);
        check("restart_1112", cur, 16'h1112);

`ifdef LOAD_CHECK_EN
        drive_load(16'h0800, 1'b0);
        check("legal_noerr", {15'd0, load_err}, 16'd0);
        pulses(2);
        drive_load(16'h2400, 1'b1);
        check("ill_2400_time", cur, 16'h0800);
        check("ill_2400_err", {15'd0, load_err}, 16'd1);
        @(negedge clock);
        check("ill_2400_errlow", {15'd0, load_err}, 16'd0);
        drive_load(16'h2570, 1'b0);
        check("ill_2570_time", cur, 16'h0800);
        check("ill_2570_err", {15'd0, load_err}, 16'd1);
        // Seconds count survived both rejected loads (2 already counted)
        pulses(SPM - 3);
        check("ill_keep_pre", cur, 16'h0800);
        pulses(1);
        check("ill_keep_0801", cur, 16'h0801);
`else
        wrap_case("raw_2759", 16'h2759, 16'h0000);
        wrap_case("raw_0a59", 16'h0A59, 16'h1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
